barcode_mimic_q: RTL and testbench

- Parametrised successor to the single-shot barcode transmitter model used in the Follower benches.
- Holds a queue of station IDs and serialises each one onto the BC line as a pulse-width-coded barcode frame: a start cell, then ID_W data cells MSB first.
- Cell period is programmable at run time.
- Emits a BC_done strobe per frame, so benches can script back-to-back station passes without re-handshaking for each one.

---
 rtl/barcode_mimic_q.sv | 170 +++++++++++++++++
 tb/tb_barcode_mimic_q.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/barcode_mimic_q.sv
// Queued pulse-width barcode transmitter: start cell plus ID_W data cells MSB first,
// then a fixed idle gap. Define BC_PARITY_EN to append an even-parity cell to every frame.
module barcode_mimic_q #(
   parameter int ID_W     = 8,
   parameter int PERIOD_W = 22,
   parameter int DEPTH    = 4,
   parameter int GAP_CYC  = 64
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [PERIOD_W-1:0]    period,
   input  logic                   send,
   input  logic [ID_W-1:0]        station_ID,
   output logic                   BC,
   output logic                   BC_done,
   output logic                   busy,
   output logic                   full,
   output logic [$clog2(DEPTH):0] q_cnt,
   output logic                   ovf
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int BW = (ID_W > 1) ? $clog2(ID_W) : 1;
   localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

`ifdef BC_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PAR, GAP} state_t;
`else
   typedef enum logic [2:0] {IDLE, START, DATA, GAP} state_t;
`endif

   state_t                r_state, w_nxt;
   logic [ID_W-1:0]       r_mem [DEPTH];
   logic [AW-1:0]         r_wp, r_rp;
   logic [CW-1:0]         r_cnt;
   logic                  r_ovf;
   logic [ID_W-1:0]       r_sr;
   logic [PERIOD_W-1:0]   r_per, r_cell;
   logic [BW-1:0]         r_bit;
   logic [GW-1:0]         r_gap;
   logic                  r_bc, r_done;
`ifdef BC_PARITY_EN
   logic                  r_par;
`endif

   logic                  w_full, w_pop, w_push, w_cell_end, w_gap_end;
   logic                  w_cur_bit, w_in_cell, w_bc_nxt;
   logic [PERIOD_W-1:0]   w_q, w_h, w_t, w_low_len;

   function automatic logic [PERIOD_W-1:0] f_clamp_period(input logic [PERIOD_W-1:0] p);
      return (p < PERIOD_W'(4)) ? PERIOD_W'(4) : p;
   endfunction

   assign w_full     = (r_cnt == CW'(DEPTH));
   assign w_pop      = (r_state == IDLE) && (r_cnt != '0);
   // A push into a full queue is still accepted when the head leaves in the same cycle.
   assign w_push     = send && (!w_full || w_pop);
   assign w_cell_end = (r_cell == r_per - PERIOD_W'(1));
   assign w_gap_end  = (r_gap == GW'(GAP_CYC - 1));

   assign w_q = r_per >> 2;
   assign w_h = r_per >> 1;
   assign w_t = w_h + w_q;

   always_comb begin
      w_cur_bit = r_sr[ID_W-1];
      w_in_cell = 1'b0;
      w_low_len = w_h;
      case (r_state)
         START: w_in_cell = 1'b1;
         DATA: begin
            w_in_cell = 1'b1;
            w_low_len = w_cur_bit ? w_q : w_t;
         end
`ifdef BC_PARITY_EN
         PAR: begin
            w_cur_bit = r_par;
            w_in_cell = 1'b1;
            w_low_len = r_par ? w_q : w_t;
         end
`endif
         default: ;
      endcase
   end

   assign w_bc_nxt = !(w_in_cell && (r_cell < w_low_len));

   always_comb begin
      w_nxt = r_state;
      case (r_state)
         IDLE:  if (w_pop) w_nxt = START;
         START: if (w_cell_end) w_nxt = DATA;
         DATA: begin
            if (w_cell_end && (r_bit == '0)) begin
`ifdef BC_PARITY_EN
               w_nxt = PAR;
`else
               w_nxt = GAP;
`endif
            end
         end
`ifdef BC_PARITY_EN
         PAR:   if (w_cell_end) w_nxt = GAP;
`endif
         GAP:   if (w_gap_end) w_nxt = IDLE;
         default: w_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wp] <= station_ID;
   end

   // Queue control, FSM and line register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_wp    <= '0;
         r_rp    <= '0;
         r_cnt   <= '0;
         r_ovf   <= 1'b0;
         r_cell  <= '0;
         r_bit   <= '0;
         r_gap   <= '0;
         r_bc    <= 1'b1;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_nxt;
         if (w_push) r_wp <= r_wp + AW'(1);
         if (w_pop)  r_rp <= r_rp + AW'(1);
         if (w_push && !w_pop)      r_cnt <= r_cnt + CW'(1);
         else if (w_pop && !w_push) r_cnt <= r_cnt - CW'(1);
         if (send && w_full && !w_pop) r_ovf <= 1'b1;

         if (w_in_cell && !w_cell_end) r_cell <= r_cell + PERIOD_W'(1);
         else                          r_cell <= '0;

         if (r_state == START && w_cell_end)     r_bit <= BW'(ID_W - 1);
         else if (r_state == DATA && w_cell_end) r_bit <= r_bit - BW'(1);

         if (r_state == GAP && !w_gap_end) r_gap <= r_gap + GW'(1);
         else                              r_gap <= '0;

         r_bc   <= w_bc_nxt;
         r_done <= (r_state == GAP) && (r_gap == '0);
      end
   end

   // Frame data: loaded at pop, shifted at each data-cell boundary
   always_ff @(posedge clk) begin
      if (w_pop) begin
         r_sr  <= r_mem[r_rp];
         r_per <= f_clamp_period(period);
`ifdef BC_PARITY_EN
         r_par <= ^r_mem[r_rp];
`endif
      end else if (r_state == DATA && w_cell_end) begin
         r_sr <= {r_sr[ID_W-2:0], 1'b0};
      end
   end

   assign BC      = r_bc;
   assign BC_done = r_done;
   assign busy    = (r_state != IDLE) || (r_cnt != '0);
   assign full    = w_full;
   assign q_cnt   = r_cnt;
   assign ovf     = r_ovf;

endmodule

// File: tb/tb_barcode_mimic_q.sv
// Scoreboard bench for barcode_mimic_q: a negedge monitor decodes BC frames,
// scenario tasks push expected IDs and compare decoded frames and timings.
`timescale 1ns/1ps
module tb_barcode_mimic_q;
   localparam int ID_W = 8, PERIOD_W = 22, DEPTH = 4, GAP_CYC = 64;
`ifdef BC_PARITY_EN
   localparam int NB = ID_W + 1;
`else
   localparam int NB = ID_W;
`endif

   logic                clk = 1'b0;
   logic                rst_n;
   logic [PERIOD_W-1:0] period;
   logic                send;
   logic [ID_W-1:0]     station_ID;
   logic                BC, BC_done, busy, full, ovf;
   logic [2:0]          q_cnt;

   int errors = 0;
   int checks = 0;

   logic [7:0]  exp_q[$];
   logic [15:0] got_sh[$];
   int          got_fall[$], got_done[$], got_start[$], lows_q[$];
   int          cyc, done_cnt;
   int          rd = 0;

   barcode_mimic_q #(.ID_W(ID_W), .PERIOD_W(PERIOD_W), .DEPTH(DEPTH), .GAP_CYC(GAP_CYC)) dut (
      .clk(clk), .rst_n(rst_n), .period(period), .send(send), .station_ID(station_ID),
      .BC(BC), .BC_done(BC_done), .busy(busy), .full(full), .q_cnt(q_cnt), .ovf(ovf)
   );

   always #5 clk = ~clk;

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Frame decoder: start-cell low width is the reference; shorter lows are 1-cells.
   initial begin
      int low, nb, st, fall;
      logic infr;
      logic [15:0] sh;
      low = 0; nb = 0; st = 0; fall = 0; infr = 1'b0; sh = '0;
      cyc = 0; done_cnt = 0;
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst_n) begin
            infr = 1'b0;
            low  = 0;
         end else begin
            if (BC_done) begin
               done_cnt++;
               got_sh.push_back(sh);
               got_fall.push_back(fall);
               got_done.push_back(cyc);
               got_start.push_back(st);
               infr = 1'b0;
            end
            if (BC == 1'b0) begin
               if (!infr) begin
                  infr = 1'b1; fall = cyc; nb = -1; sh = '0;
               end
               low++;
            end else if (low != 0) begin
               lows_q.push_back(low);
               if (nb < 0) st = low;
               else        sh = {sh[14:0], (low < st)};
               nb++;
               low = 0;
            end
         end
      end
   end

   task automatic push(input logic [7:0] id, input bit accept);
      send = 1'b1;
      station_ID = id;
      if (accept) exp_q.push_back(id);
      @(posedge clk); #1;
      send = 1'b0;
   endtask

   task automatic wait_frames(input int n, input int budget, output bit ok);
      int t;
      t = 0;
      while (got_sh.size() < n && t < budget) begin
         @(posedge clk); t++;
      end
      ok = (got_sh.size() >= n);
   endtask

   task automatic test_reset;
      rst_n = 1'b0; send = 1'b0; station_ID = '0; period = 22'h1000;
      repeat (3) @(posedge clk);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      checks++; if (BC !== 1'b1)      begin errors++; $display("FAIL reset_BC got=%b want=1", BC); end
      checks++; if (BC_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", BC_done); end
      checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
      checks++; if (full !== 1'b0)    begin errors++; $display("FAIL reset_full got=%b want=0", full); end
      checks++; if (q_cnt !== 3'd0)   begin errors++; $display("FAIL reset_qcnt got=%0d want=0", q_cnt); end
      checks++; if (ovf !== 1'b0)     begin errors++; $display("FAIL reset_ovf got=%b want=0", ovf); end
   endtask

   task automatic test_single;
      int base, lb, d0;
      bit ok;
      logic [7:0] e, g;
      period = 22'h1000;
      base = got_sh.size(); lb = lows_q.size(); d0 = done_cnt;
      push(8'h01, 1'b1);
      checks++; if (q_cnt !== 3'd1) begin errors++; $display("FAIL single_qcnt1 got=%0d want=1", q_cnt); end
      checks++; if (BC !== 1'b1)    begin errors++; $display("FAIL single_bc_k got=%b want=1", BC); end
      @(posedge clk); #1;
      checks++; if (q_cnt !== 3'd0 || busy !== 1'b1 || BC !== 1'b1)
         begin errors++; $display("FAIL single_pop got q=%0d busy=%b bc=%b want q=0 busy=1 bc=1", q_cnt, busy, BC); end
      @(posedge clk); #1;
      checks++; if (BC !== 1'b0) begin errors++; $display("FAIL single_fall got=%b want=0", BC); end
      wait_frames(base + 1, 45000, ok);
      checks++; if (!ok) begin errors++; $display("FAIL single_timeout got=%0d frames want=%0d", got_sh.size(), base + 1); end
      if (ok) begin
         e = exp_q.pop_front();
         g = 8'(got_sh[rd] >> (NB - ID_W));
         checks++; if (g !== e) begin errors++; $display("FAIL single_id got=%h want=%h", g, e); end
         checks++; if (lows_q[lb] != 2048) begin errors++; $display("FAIL single_start got=%0d want=2048", lows_q[lb]); end
         for (int i = 1; i <= 7; i++) begin
            checks++; if (lows_q[lb+i] != 3072) begin errors++; $display("FAIL single_zero%0d got=%0d want=3072", i, lows_q[lb+i]); end
         end
         checks++; if (lows_q[lb+8] != 1024) begin errors++; $display("FAIL single_one got=%0d want=1024", lows_q[lb+8]); end
         checks++; if (got_done[rd] - got_fall[rd] != (NB + 1) * 4096)
            begin errors++; $display("FAIL single_done_time got=%0d want=%0d", got_done[rd] - got_fall[rd], (NB + 1) * 4096); end
         rd++;
      end
      repeat (100) @(posedge clk); #1;
      checks++; if (done_cnt != d0 + 1) begin errors++; $display("FAIL single_done_cnt got=%0d want=%0d", done_cnt, d0 + 1); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle_busy got=%b want=0", busy); end
   endtask

   task automatic test_queue;
      int base, d0;
      bit ok;
      logic [7:0] e, g;
      period = 22'd16;
      base = got_sh.size(); d0 = done_cnt;
      push(8'h02, 1'b1);
      checks++; if (q_cnt !== 3'd1) begin errors++; $display("FAIL queue_q1 got=%0d want=1", q_cnt); end
      push(8'h01, 1'b1);
      checks++; if (q_cnt !== 3'd1) begin errors++; $display("FAIL queue_q2 got=%0d want=1", q_cnt); end
      push(8'hA5, 1'b1);
      checks++; if (q_cnt !== 3'd2) begin errors++; $display("FAIL queue_q3 got=%0d want=2", q_cnt); end
      wait_frames(base + 3, 1500, ok);
      checks++; if (!ok) begin errors++; $display("FAIL queue_timeout got=%0d frames want=%0d", got_sh.size(), base + 3); end
      if (ok) begin
         for (int f = 0; f < 3; f++) begin
            e = exp_q.pop_front();
            g = 8'(got_sh[rd] >> (NB - ID_W));
            checks++; if (g !== e) begin errors++; $display("FAIL queue_id%0d got=%h want=%h", f, g, e); end
            if (f > 0) begin
               checks++; if (got_fall[rd] - got_done[rd-1] < GAP_CYC)
                  begin errors++; $display("FAIL queue_gap%0d got=%0d want>=%0d", f, got_fall[rd] - got_done[rd-1], GAP_CYC); end
            end
            rd++;
         end
      end
      repeat (100) @(posedge clk); #1;
      checks++; if (done_cnt != d0 + 3) begin errors++; $display("FAIL queue_done_cnt got=%0d want=%0d", done_cnt, d0 + 3); end
   endtask

   task automatic test_overflow;
      int base;
      bit ok;
      logic [7:0] e, g;
      period = 22'd16;
      base = got_sh.size();
      push(8'h11, 1'b1);
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) push(8'(8'h20 + i), 1'b1);
      checks++; if (full !== 1'b1 || q_cnt !== 3'd4) begin errors++; $display("FAIL ovf_full got full=%b q=%0d want full=1 q=4", full, q_cnt); end
      checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_early got=%b want=0", ovf); end
      push(8'h24, 1'b0);
      checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_set got=%b want=1", ovf); end
      checks++; if (q_cnt !== 3'd4) begin errors++; $display("FAIL ovf_qcnt got=%0d want=4", q_cnt); end
      wait_frames(base + 5, 1500, ok);
      repeat (300) @(posedge clk); #1;
      checks++; if (got_sh.size() != base + 5) begin errors++; $display("FAIL ovf_frames got=%0d want=%0d", got_sh.size() - base, 5); end
      if (ok) begin
         for (int f = 0; f < 5; f++) begin
            e = exp_q.pop_front();
            g = 8'(got_sh[rd] >> (NB - ID_W));
            checks++; if (g !== e) begin errors++; $display("FAIL ovf_id%0d got=%h want=%h", f, g, e); end
            rd++;
         end
      end
      checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%b want=1", ovf); end
   endtask

   task automatic test_clamp;
      int base, lb, t;
      bit ok;
      logic [7:0] e, g, id1;
      id1 = 8'h5A;
      period = 22'd2;
      base = got_sh.size(); lb = lows_q.size();
      push(id1, 1'b1);
      t = 0;
      while (BC !== 1'b0 && t < 20) begin @(posedge clk); #1; t++; end
      period = 22'd8;
      push(8'hC3, 1'b1);
      wait_frames(base + 2, 800, ok);
      checks++; if (!ok) begin errors++; $display("FAIL clamp_timeout got=%0d frames want=%0d", got_sh.size(), base + 2); end
      if (ok) begin
         checks++; if (lows_q[lb] != 2) begin errors++; $display("FAIL clamp_start1 got=%0d want=2", lows_q[lb]); end
         for (int i = 0; i < 8; i++) begin
            checks++; if (lows_q[lb+1+i] != (id1[7-i] ? 1 : 3))
               begin errors++; $display("FAIL clamp_cell%0d got=%0d want=%0d", i, lows_q[lb+1+i], id1[7-i] ? 1 : 3); end
         end
         checks++; if (got_done[rd] - got_fall[rd] != (NB + 1) * 4)
            begin errors++; $display("FAIL clamp_len1 got=%0d want=%0d", got_done[rd] - got_fall[rd], (NB + 1) * 4); end
         checks++; if (got_start[rd+1] != 4) begin errors++; $display("FAIL clamp_start2 got=%0d want=4", got_start[rd+1]); end
         checks++; if (got_done[rd+1] - got_fall[rd+1] != (NB + 1) * 8)
            begin errors++; $display("FAIL clamp_len2 got=%0d want=%0d", got_done[rd+1] - got_fall[rd+1], (NB + 1) * 8); end
         for (int f = 0; f < 2; f++) begin
            e = exp_q.pop_front();
            g = 8'(got_sh[rd] >> (NB - ID_W));
            checks++; if (g !== e) begin errors++; $display("FAIL clamp_id%0d got=%h want=%h", f, g, e); end
            rd++;
         end
      end
      repeat (100) @(posedge clk); #1;
   endtask

   task automatic test_reset_mid;
      int d0, t;
      period = 22'd16;
      push(8'h00, 1'b1);
      push(8'h33, 1'b1);
      t = 0;
      while (BC !== 1'b0 && t < 20) begin @(posedge clk); #1; t++; end
      repeat (18) @(posedge clk);
      #1;
      checks++; if (BC !== 1'b0) begin errors++; $display("FAIL rmid_pre_bc got=%b want=0", BC); end
      #1 rst_n = 1'b0;
      #1;
      checks++; if (BC !== 1'b1)    begin errors++; $display("FAIL rmid_bc got=%b want=1", BC); end
      checks++; if (q_cnt !== 3'd0) begin errors++; $display("FAIL rmid_qcnt got=%0d want=0", q_cnt); end
      checks++; if (ovf !== 1'b0)   begin errors++; $display("FAIL rmid_ovf got=%b want=0", ovf); end
      checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL rmid_busy got=%b want=0", busy); end
      exp_q.delete();
      @(posedge clk); #2;
      rst_n = 1'b1;
      d0 = done_cnt;
      repeat (300) @(posedge clk); #1;
      checks++; if (done_cnt != d0) begin errors++; $display("FAIL rmid_no_done got=%0d want=%0d", done_cnt, d0); end
      checks++; if (BC !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL rmid_idle got bc=%b busy=%b want bc=1 busy=0", BC, busy); end
      rd = got_sh.size();
   endtask

`ifdef BC_PARITY_EN
   task automatic test_parity;
      int base, lb;
      bit ok;
      logic [7:0] e, g;
      period = 22'd16;
      base = got_sh.size(); lb = lows_q.size();
      push(8'h07, 1'b1);
      push(8'h03, 1'b1);
      wait_frames(base + 2, 1000, ok);
      checks++; if (!ok) begin errors++; $display("FAIL par_timeout got=%0d frames want=%0d", got_sh.size(), base + 2); end
      if (ok) begin
         checks++; if (got_sh[rd][0] !== 1'b1) begin errors++; $display("FAIL par_bit07 got=%b want=1", got_sh[rd][0]); end
         checks++; if (lows_q[lb+9] != 4) begin errors++; $display("FAIL par_cell07 got=%0d want=4", lows_q[lb+9]); end
         checks++; if (got_sh[rd+1][0] !== 1'b0) begin errors++; $display("FAIL par_bit03 got=%b want=0", got_sh[rd+1][0]); end
         checks++; if (lows_q[lb+19] != 12) begin errors++; $display("FAIL par_cell03 got=%0d want=12", lows_q[lb+19]); end
         checks++; if (got_done[rd] - got_fall[rd] != 10 * 16)
            begin errors++; $display("FAIL par_len got=%0d want=%0d", got_done[rd] - got_fall[rd], 160); end
         for (int f = 0; f < 2; f++) begin
            e = exp_q.pop_front();
            g = 8'(got_sh[rd] >> 1);
            checks++; if (g !== e) begin errors++; $display("FAIL par_id%0d got=%h want=%h", f, g, e); end
            rd++;
         end
      end
      repeat (100) @(posedge clk); #1;
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_queue();
      test_overflow();
      test_clamp();
`ifdef BC_PARITY_EN
      test_parity();
`endif
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
